// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite LED responder: register offsets,
// response codes and the channel FSM state encodings.
package axi_lite_pkg;

    // Register offsets within the 16-byte window (addr[1:0] always zero)
    localparam logic [3:0] REG_LED_OUT   = 4'h0;
    localparam logic [3:0] REG_SWITCHES  = 4'h4;
    localparam logic [3:0] REG_BTN_EVENT = 4'h8;
    localparam logic [3:0] REG_ID        = 4'hC;

    // AXI response codes used by this block
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    // Read channel FSM
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Turn the decoded word index addr[3:2] back into a byte offset
    function automatic logic [3:0] reg_offset(input logic [1:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/axi4_lite_led_slave.sv
// AXI4-Lite responder holding the LED output register, synchronised
// switch status, a sticky button-event flag and a constant ID word.
//
// Handshake rule on every channel: a transfer happens at the rising clk
// edge where VALID and READY are both 1. A source never drops VALID or
// changes its payload before that edge; this block's READY outputs are
// registered and do not depend combinationally on any VALID input.
module axi4_lite_led_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h4C45_4430,
    parameter int          SW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [15:0]         leds,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                button,

    input  logic [31:0]         S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,

    input  logic [31:0]         S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [31:0]         S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    // ---------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------
    logic [SW_WIDTH-1:0] sw_sync;
    logic                btn_sync;

    sync_2ff #(.WIDTH(SW_WIDTH)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (switches),
        .q_o   (sw_sync)
    );

    sync_2ff #(.WIDTH(1)) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (button),
        .q_o   (btn_sync)
    );

    // ---------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------
    logic [15:0] led_q,       led_d;
    logic        btn_event_q, btn_event_d;
    logic        btn_prev_q;
    logic        btn_rise;
    logic        btn_clear;

    // ---------------------------------------------------------------
    // Write channel state
    // ---------------------------------------------------------------
    wr_state_e   wr_state_q;
    logic        aw_cap_q;
    logic        w_cap_q;
    logic        awready_q;
    logic        wready_q;
    logic [1:0]  waddr_q;
    logic [15:0] wdata_q;
    logic [1:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        wr_commit;
    logic [3:0]  wr_off;
    logic [1:0]  wr_bresp;

    // ---------------------------------------------------------------
    // Read channel state
    // ---------------------------------------------------------------
    rd_state_e   rd_state_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs;
    logic [31:0] rd_mux;

    // Only the word index of each address is decoded; only the LED bytes
    // of the write data and strobes carry state.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

    assign aw_hs     = S_AXI_AWVALID && awready_q;
    assign w_hs      = S_AXI_WVALID  && wready_q;
    assign ar_hs     = S_AXI_ARVALID && arready_q;

    // The register update happens in the cycle after both halves landed
    assign wr_commit = (wr_state_q == W_IDLE) && aw_cap_q && w_cap_q;
    assign wr_off    = reg_offset(waddr_q);
    assign wr_bresp  = ((wr_off == REG_LED_OUT) || (wr_off == REG_BTN_EVENT))
                       ? RESP_OKAY : RESP_SLVERR;

    assign btn_rise  = btn_sync && !btn_prev_q;
    assign btn_clear = wr_commit && (wr_off == REG_BTN_EVENT)
                       && wstrb_q[0] && wdata_q[0];

    // Next value of LED_OUT: byte-wise strobed write when committed
    always_comb begin
        led_d = led_q;
        if (wr_commit && (wr_off == REG_LED_OUT)) begin
            if (wstrb_q[0]) led_d[7:0]  = wdata_q[7:0];
            if (wstrb_q[1]) led_d[15:8] = wdata_q[15:8];
        end
    end

    // Next value of BTN_EVENT: a new rising edge beats a same-cycle W1C
    always_comb begin
        btn_event_d = btn_event_q;
        if (btn_rise) begin
            btn_event_d = 1'b1;
        end else if (btn_clear) begin
            btn_event_d = 1'b0;
        end
    end

    // Register file and button edge-detect flops
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q       <= '0;
            btn_event_q <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            led_q       <= led_d;
            btn_event_q <= btn_event_d;
            btn_prev_q  <= btn_sync;
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold B
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (aw_cap_q && w_cap_q) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_bresp;
                        wr_state_q <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_cap_q <= 1'b1;
                            waddr_q  <= S_AXI_AWADDR[3:2];
                        end
                        if (w_hs) begin
                            w_cap_q <= 1'b1;
                            wdata_q <= S_AXI_WDATA[15:0];
                            wstrb_q <= S_AXI_WSTRB[1:0];
                        end
                        awready_q <= !(aw_cap_q || aw_hs);
                        wready_q  <= !(w_cap_q  || w_hs);
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        aw_cap_q   <= 1'b0;
                        w_cap_q    <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read data selection from the current (pre-update) register values
    always_comb begin
        rd_mux = '0;
        unique case (reg_offset(S_AXI_ARADDR[3:2]))
            REG_LED_OUT:   rd_mux = {16'h0000, led_q};
            REG_SWITCHES:  rd_mux = 32'(sw_sync);
            REG_BTN_EVENT: rd_mux = {31'h0, btn_event_q};
            REG_ID:        rd_mux = ID_VALUE;
            default:       rd_mux = '0;
        endcase
    end

    // Read FSM: capture on AR, hold R stable until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q    <= rd_mux;
                        rresp_q    <= RESP_OKAY;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign leds          = led_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule
